// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect requests, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage; master is the surrounding pipeline.
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        ifid_valid;
   logic [63:0] ifid_pc;
   logic [63:0] ifid_pc_plus4;
   logic [31:0] ifid_instr;
   logic        fetch_fault;
   logic [63:0] fault_pc;
   logic [31:0] fetch_count;

   modport slave (
      input  stall, flush, redirect_valid, redirect_target, imem_instr,
      output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
             fetch_fault, fault_pc, fetch_count
   );

   modport master (
      output stall, flush, redirect_valid, redirect_target, imem_instr,
      input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
             fetch_fault, fault_pc, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, registers imem data into IF/ID, handles stall/flush/redirect,
// halts on an illegal fetch address until redirected, and counts delivered instructions.
module fetch_stage #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          IMEM_BYTES = 512,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.slave  bus
);
   localparam logic [0:0]  RUN     = 1'b0;
   localparam logic [0:0]  HALT    = 1'b1;
   localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);

   logic [0:0]  r_state;
   logic [63:0] r_pc;
   logic        r_valid;
   logic [63:0] r_ifid_pc;
   logic [63:0] r_ifid_pc4;
   logic [31:0] r_ifid_instr;
   logic        r_fault;
   logic [63:0] r_fault_pc;
   logic [31:0] r_count;

   logic        w_legal;
   logic [63:0] w_pc4;

   // Full-width compare so any high address bit makes the fetch illegal.
   assign w_legal = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);
   assign w_pc4   = r_pc + 64'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_pc         <= RESET_PC;
         r_valid      <= 1'b0;
         r_ifid_pc    <= '0;
         r_ifid_pc4   <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_fault      <= 1'b0;
         r_fault_pc   <= '0;
         r_count      <= '0;
      end else if (bus.redirect_valid) begin
         // Target legality is only checked once it becomes the current PC.
         r_pc         <= bus.redirect_target;
         r_valid      <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
         r_state      <= RUN;
         r_fault      <= 1'b0;
      end else if (r_state == HALT) begin
         r_state <= HALT;
      end else if (bus.stall) begin
         if (bus.flush) begin
            r_valid      <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
         end
      end else if (!w_legal) begin
         r_state      <= HALT;
         r_fault      <= 1'b0 | 1'b1;
         r_fault_pc   <= r_pc;
         r_valid      <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
      end else if (bus.flush) begin
         r_valid      <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
         r_pc         <= w_pc4;
      end else begin
         r_valid      <= 1'b1;
         r_ifid_pc    <= r_pc;
         r_ifid_pc4   <= w_pc4;
         r_ifid_instr <= bus.imem_instr;
         r_pc         <= w_pc4;
         if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
      end
   end

   assign bus.imem_addr     = r_pc;
   assign bus.ifid_valid    = r_valid;
   assign bus.ifid_pc       = r_ifid_pc;
   assign bus.ifid_pc_plus4 = r_ifid_pc4;
   assign bus.ifid_instr    = r_ifid_instr;
   assign bus.fetch_fault   = r_fault;
   assign bus.fault_pc      = r_fault_pc;
   assign bus.fetch_count   = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes expected IF/ID state per cycle
// into a scoreboard queue, checked after each edge, plus fixed-value checks at key points.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      logic [63:0] pc;
      logic        v;
      logic [63:0] ipc;
      logic [63:0] ipc4;
      logic [31:0] instr;
      logic        fault;
      logic [63:0] fpc;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t m;
   logic m_halt;

   fetch_stage_if bus ();

   fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] memrd(input logic [63:0] a);
      if (a < 64'd512) return {16'hC0DE, a[15:0]};
      return 32'hDEAD_BEEF;
   endfunction

   assign bus.imem_instr = memrd(bus.imem_addr);

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m.pc = 64'h0; m.v = 1'b0; m.ipc = '0; m.ipc4 = '0; m.instr = NOP;
      m.fault = 1'b0; m.fpc = '0; m.cnt = '0; m_halt = 1'b0;
   endtask

   task automatic check_all(input exp_t e, input string tag);
      chk({tag, ".addr"},  bus.imem_addr, e.pc);
      chk({tag, ".valid"}, 64'(bus.ifid_valid), 64'(e.v));
      chk({tag, ".pc"},    bus.ifid_pc, e.ipc);
      chk({tag, ".pc4"},   bus.ifid_pc_plus4, e.ipc4);
      chk({tag, ".instr"}, 64'(bus.ifid_instr), 64'(e.instr));
      chk({tag, ".fault"}, 64'(bus.fetch_fault), 64'(e.fault));
      chk({tag, ".fpc"},   bus.fault_pc, e.fpc);
      chk({tag, ".cnt"},   64'(bus.fetch_count), 64'(e.cnt));
   endtask

   // Drive one cycle of requests, predict the result, then compare after the edge.
   task automatic step(input logic st, input logic fl, input logic rv, input logic [63:0] rt);
      logic legal;
      exp_t e;
      bus.stall = st; bus.flush = fl; bus.redirect_valid = rv; bus.redirect_target = rt;
      legal = (m.pc[1:0] == 2'b00) && (m.pc <= 64'd508);
      if (rv) begin
         m.pc = rt; m.v = 1'b0; m.instr = NOP; m_halt = 1'b0; m.fault = 1'b0;
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (st) begin
         if (fl) begin m.v = 1'b0; m.instr = NOP; end
      end else if (!legal) begin
         m_halt = 1'b1; m.fault = 1'b1; m.fpc = m.pc; m.v = 1'b0; m.instr = NOP;
      end else if (fl) begin
         m.v = 1'b0; m.instr = NOP; m.pc = m.pc + 64'd4;
      end else begin
         m.v = 1'b1; m.ipc = m.pc; m.ipc4 = m.pc + 64'd4; m.instr = memrd(m.pc);
         m.pc = m.pc + 64'd4;
         if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 32'd1;
      end
      sb.push_back(m);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(e, "sb");
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".addr"},  bus.imem_addr, 64'h0);
      chk({tag, ".valid"}, 64'(bus.ifid_valid), 64'h0);
      chk({tag, ".pc"},    bus.ifid_pc, 64'h0);
      chk({tag, ".pc4"},   bus.ifid_pc_plus4, 64'h0);
      chk({tag, ".instr"}, 64'(bus.ifid_instr), 64'(NOP));
      chk({tag, ".fault"}, 64'(bus.fetch_fault), 64'h0);
      chk({tag, ".fpc"},   bus.fault_pc, 64'h0);
      chk({tag, ".cnt"},   64'(bus.fetch_count), 64'h0);
   endtask

   initial begin
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;

      // W0, W1, then stall three cycles at pc=8, then W2, W3.
      step(0, 0, 0, '0);
      chk("w0.instr", 64'(bus.ifid_instr), 64'hC0DE0000);
      step(0, 0, 0, '0);
      repeat (3) step(1, 0, 0, '0);
      chk("stall.addr", bus.imem_addr, 64'd8);
      chk("stall.ipc", bus.ifid_pc, 64'd4);
      chk("stall.cnt", 64'(bus.fetch_count), 64'd2);
      step(0, 0, 0, '0);
      chk("w2.ipc", bus.ifid_pc, 64'd8);
      chk("w2.instr", 64'(bus.ifid_instr), 64'hC0DE0008);
      step(0, 0, 0, '0);
      chk("w3.pc4", bus.ifid_pc_plus4, 64'd16);
      chk("w3.cnt", 64'(bus.fetch_count), 64'd4);

      // Redirect wins over simultaneous stall and flush.
      step(1, 1, 1, 64'h40);
      chk("redir.valid", 64'(bus.ifid_valid), 64'h0);
      chk("redir.addr", bus.imem_addr, 64'h40);
      step(0, 0, 0, '0);
      chk("redir.instr", 64'(bus.ifid_instr), 64'hC0DE0040);

      // Run off the end of memory: 508 is the last legal fetch.
      step(0, 0, 1, 64'd500);
      repeat (3) step(0, 0, 0, '0);
      chk("last.ipc", bus.ifid_pc, 64'd508);
      step(0, 0, 0, '0);
      chk("oob.fault", 64'(bus.fetch_fault), 64'h1);
      chk("oob.fpc", bus.fault_pc, 64'd512);
      repeat (10) step(0, 0, 0, '0);
      chk("halt.addr", bus.imem_addr, 64'd512);
      chk("halt.cnt", 64'(bus.fetch_count), 64'd8);
      step(0, 0, 1, 64'h0);
      chk("clr.fault", 64'(bus.fetch_fault), 64'h0);
      step(0, 0, 0, '0);
      chk("resume.instr", 64'(bus.ifid_instr), 64'hC0DE0000);

      // Flush at a legal PC advances without counting.
      step(0, 1, 0, '0);
      chk("flush.addr", bus.imem_addr, 64'd8);
      chk("flush.cnt", 64'(bus.fetch_count), 64'd9);

      // Misaligned target halts on the following cycle.
      step(0, 0, 1, 64'h6);
      step(0, 0, 0, '0);
      chk("misal.fpc", bus.fault_pc, 64'h6);

      // A stalled illegal PC does not fault until the stall drops.
      step(1, 0, 1, 64'd600);
      repeat (3) step(1, 0, 0, '0);
      chk("stall600.fault", 64'(bus.fetch_fault), 64'h0);
      step(0, 0, 0, '0);
      chk("pc600.fpc", bus.fault_pc, 64'd600);

      step(0, 0, 1, 64'h0);
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      chk("pre_rst.cnt", 64'(bus.fetch_count), 64'd11);

      // Asynchronous reset between edges clears everything immediately.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
      model_reset();
      #1;
      rst_n = 1'b1;
      step(0, 0, 0, '0);
      chk("restart.instr", 64'(bus.ifid_instr), 64'hC0DE0000);
      chk("restart.cnt", 64'(bus.fetch_count), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
